// File: rtl/aidc_lite_apb_cfg_if.sv
// -----------------------------------------------------------------------------
// aidc_lite_apb_cfg_if
// APB3 bus bundle between the system APB master and the AIDC-Lite config block.
//   psel/penable/paddr/pwrite/pwdata : master -> completer
//   pready/prdata/pslverr            : completer -> master
// The master modport is the requester side; the slave modport is the completer.
// -----------------------------------------------------------------------------
interface aidc_lite_apb_cfg_if #(
    parameter int PADDR_W = 32
) ();
    logic               psel;
    logic               penable;
    logic [PADDR_W-1:0] paddr;
    logic               pwrite;
    logic [31:0]        pwdata;
    logic               pready;
    logic [31:0]        prdata;
    logic               pslverr;

    modport master (
        output psel, penable, paddr, pwrite, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/aidc_lite_apb_cfg.sv
// -----------------------------------------------------------------------------
// aidc_lite_apb_cfg
// APB3 completer holding the control/status registers of one AIDC-Lite DMA
// engine. Software programs SRC/DST/LEN, kicks the engine through CMD and
// polls STATUS (busy/done); done also drives a level interrupt.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   apb          APB3 completer side (psel/penable/paddr/pwrite/pwdata in,
//                pready/prdata/pslverr out)
//   o_src_addr   engine source address (SRC)
//   o_dst_addr   engine destination address (DST)
//   o_len        engine byte length (LEN)
//   o_start      one-cycle start pulse, the cycle after the CMD write commits
//   i_done_in    one-cycle completion pulse from the engine
//   o_irq        level interrupt, equal to STATUS.done
//
// Register map (offset = paddr[4:0], paddr[PADDR_W-1:5] must be zero)
//   0x00 SRC  RW   0x04 DST RW   0x08 LEN RW   (bits [1:0] forced to 0)
//   0x0C CMD  WO   bit0=1 starts the engine, reads 0
//   0x10 STATUS {30'b0, busy, done}, write bit0=1 clears done
// -----------------------------------------------------------------------------
module aidc_lite_apb_cfg #(
    parameter int PADDR_W     = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    aidc_lite_apb_cfg_if.slave   apb,
    output logic [31:0]          o_src_addr,
    output logic [31:0]          o_dst_addr,
    output logic [31:0]          o_len,
    output logic                 o_start,
    input  logic                 i_done_in,
    output logic                 o_irq
);
    localparam logic [2:0] LP_WS = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [2:0]  r_wcnt;
    logic        r_setup_seen;
    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic [31:0] r_len;
    logic        r_start;
    logic        r_irq;

    logic        w_setup;
    logic        w_access;
    logic        w_ready;
    logic [2:0]  w_off;
    logic        w_unmapped;
    logic        w_busy;
    logic        w_done;
    logic        w_cmd_go;
    logic        w_err;
    logic        w_commit;
    logic        w_go;
    logic        w_w1c;
    logic [31:0] w_rdata;

    // An access phase only counts if its setup phase was seen after reset;
    // this is what aborts a transfer that was in flight when reset hit.
    assign w_setup  = apb.psel & ~apb.penable;
    assign w_access = apb.psel & apb.penable & r_setup_seen;
    assign w_ready  = w_access & (r_wcnt == LP_WS) & ~rst;

    assign w_off      = apb.paddr[4:2];
    assign w_unmapped = (|apb.paddr[PADDR_W-1:5]) | (w_off > 3'd4);
    assign w_busy     = (r_state == ST_BUSY);
    assign w_done     = (r_state == ST_DONE);

    assign w_cmd_go = apb.pwrite & (w_off == 3'd3) & apb.pwdata[0];

    // STATUS writes stay legal while BUSY; every other write is rejected.
    assign w_err = w_unmapped
                 | (apb.pwrite & w_busy & (w_off != 3'd4))
                 | (w_cmd_go & (r_len == '0));

    assign w_commit = w_ready & apb.pwrite & ~w_err;
    assign w_go     = w_commit & w_cmd_go;
    assign w_w1c    = w_commit & (w_off == 3'd4) & apb.pwdata[0];

    always_comb begin
        w_rdata = '0;
        if (w_ready && !w_err && !apb.pwrite) begin
            case (w_off)
                3'd0:    w_rdata = r_src;
                3'd1:    w_rdata = r_dst;
                3'd2:    w_rdata = r_len;
                3'd4:    w_rdata = {30'b0, w_busy, w_done};
                default: w_rdata = '0;
            endcase
        end
    end

    assign apb.pready  = w_ready;
    assign apb.pslverr = w_ready & w_err;
    assign apb.prdata  = w_rdata;

    // Wait-state counter and setup tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt       <= '0;
            r_setup_seen <= 1'b0;
        end else begin
            if (w_access && (r_wcnt != LP_WS)) begin
                r_wcnt <= r_wcnt + 3'd1;
            end else begin
                r_wcnt <= '0;
            end

            if (w_setup) begin
                r_setup_seen <= 1'b1;
            end else if (w_ready || !apb.psel) begin
                r_setup_seen <= 1'b0;
            end
        end
    end

    // Register file and engine FSM with registered start/irq.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_start <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_start <= w_go;

            if (w_commit && (w_off == 3'd0)) r_src <= {apb.pwdata[31:2], 2'b00};
            if (w_commit && (w_off == 3'd1)) r_dst <= {apb.pwdata[31:2], 2'b00};
            if (w_commit && (w_off == 3'd2)) r_len <= {apb.pwdata[31:2], 2'b00};

            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_state <= ST_BUSY;
                        r_irq   <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    // Any CMD write here has already been turned into an error.
                    if (i_done_in) begin
                        r_state <= ST_DONE;
                        r_irq   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (w_go) begin
                        r_state <= ST_BUSY;
                        r_irq   <= 1'b0;
                    end else if (w_w1c) begin
                        r_state <= ST_IDLE;
                        r_irq   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_irq   <= 1'b0;
                end
            endcase
        end
    end

    assign o_src_addr = r_src;
    assign o_dst_addr = r_dst;
    assign o_len      = r_len;
    assign o_start    = r_start;
    assign o_irq      = r_irq;
endmodule

// File: tb/tb_aidc_lite_apb_cfg.sv
// -----------------------------------------------------------------------------
// tb_aidc_lite_apb_cfg
// Self-checking bench for aidc_lite_apb_cfg. dut0 runs with no wait states and
// carries the register/FSM tests; dut1 runs with three wait states and checks
// access-phase length and commit timing. APB responses of dut0 are checked
// against a scoreboard queue filled when each transfer is driven.
// -----------------------------------------------------------------------------
module tb_aidc_lite_apb_cfg;
    localparam int PW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aidc_lite_apb_cfg_if #(.PADDR_W(PW)) bus0 ();
    aidc_lite_apb_cfg_if #(.PADDR_W(PW)) bus1 ();

    logic [31:0] src0, dst0, len0, src1, dst1, len1;
    logic        start0, irq0, start1, irq1;
    logic        done_in0 = 1'b0;
    logic        done_in1 = 1'b0;

    aidc_lite_apb_cfg #(.PADDR_W(PW), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .apb(bus0),
        .o_src_addr(src0), .o_dst_addr(dst0), .o_len(len0),
        .o_start(start0), .i_done_in(done_in0), .o_irq(irq0)
    );

    aidc_lite_apb_cfg #(.PADDR_W(PW), .WAIT_STATES(3)) dut1 (
        .clk(clk), .rst(rst), .apb(bus1),
        .o_src_addr(src1), .o_dst_addr(dst1), .o_len(len1),
        .o_start(start1), .i_done_in(done_in1), .o_irq(irq1)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int start_cnt0 = 0;

    always @(negedge clk) begin
        if (start0) start_cnt0 <= start_cnt0 + 1;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", nm, act);
        end
    endtask

    // One APB transfer on bus0, starting from the current (post-edge) time.
    // Leaves the bus idle just after the edge that ends the access phase, so a
    // following call produces a back-to-back setup phase.
    task automatic apb0(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input logic done_on_access, input string nm);
        exp_t e;
        exp_t g;
        int   n;
        e.rdata = exp_rd;
        e.err   = exp_err;
        sb_q.push_back(e);
        bus0.psel    = 1'b1;
        bus0.penable = 1'b0;
        bus0.pwrite  = wr;
        bus0.paddr   = addr;
        bus0.pwdata  = wdata;
        @(posedge clk); #1;
        bus0.penable = 1'b1;
        if (done_on_access) done_in0 = 1'b1;
        for (n = 0; n < 16; n++) begin
            @(negedge clk);
            if (bus0.pready) break;
            @(posedge clk); #1;
            done_in0 = 1'b0;
        end
        g = sb_q.pop_front();
        if (n == 16) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s timeout: pready not seen in 16 cycles, expected 1", nm);
        end else begin
            chk({nm, " prdata"}, bus0.prdata, g.rdata);
            chk({nm, " pslverr"}, 32'(bus0.pslverr), 32'(g.err));
        end
        @(posedge clk); #1;
        done_in0     = 1'b0;
        bus0.psel    = 1'b0;
        bus0.penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.psel = 1'b0; bus0.penable = 1'b0; bus0.pwrite = 1'b0;
        bus0.paddr = '0;  bus0.pwdata = '0;
        bus1.psel = 1'b0; bus1.penable = 1'b0; bus1.pwrite = 1'b0;
        bus1.paddr = '0;  bus1.pwdata = '0;

        // ---- Reset, with an access phase held on the bus throughout ----
        rst = 1'b1;
        bus0.psel = 1'b1; bus0.penable = 1'b1; bus0.pwrite = 1'b1;
        bus0.paddr = 32'h0; bus0.pwdata = 32'hDEAD_BEEC;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst%0d pready", i),  32'(bus0.pready),  32'h0);
            chk($sformatf("rst%0d pslverr", i), 32'(bus0.pslverr), 32'h0);
            chk($sformatf("rst%0d start", i),   32'(start0),       32'h0);
            chk($sformatf("rst%0d irq", i),     32'(irq0),         32'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus0.psel = 1'b0; bus0.penable = 1'b0;
        @(posedge clk); #1;

        // ---- Table-driven register/FSM vectors on dut0 ----
        vecs.push_back('{1'b0, 32'h00, 32'h0,        32'h0,     1'b0});
        vecs.push_back('{1'b0, 32'h04, 32'h0,        32'h0,     1'b0});
        vecs.push_back('{1'b0, 32'h08, 32'h0,        32'h0,     1'b0});
        vecs.push_back('{1'b0, 32'h0C, 32'h0,        32'h0,     1'b0});
        vecs.push_back('{1'b0, 32'h10, 32'h0,        32'h0,     1'b0});
        vecs.push_back('{1'b1, 32'h00, 32'h1003,     32'h0,     1'b0});
        vecs.push_back('{1'b0, 32'h00, 32'h0,        32'h1000,  1'b0});
        vecs.push_back('{1'b1, 32'h00, 32'h0,        32'h0,     1'b0});
        vecs.push_back('{1'b1, 32'h04, 32'h20000,    32'h0,     1'b0});
        vecs.push_back('{1'b1, 32'h08, 32'h100,      32'h0,     1'b0});
        vecs.push_back('{1'b0, 32'h00, 32'h0,        32'h0,     1'b0});
        vecs.push_back('{1'b0, 32'h04, 32'h0,        32'h20000, 1'b0});
        vecs.push_back('{1'b0, 32'h08, 32'h0,        32'h100,   1'b0});
        vecs.push_back('{1'b0, 32'h14, 32'h0,        32'h0,     1'b1});
        vecs.push_back('{1'b0, 32'h20, 32'h0,        32'h0,     1'b1});
        vecs.push_back('{1'b1, 32'h1C, 32'h5,        32'h0,     1'b1});
        vecs.push_back('{1'b0, 32'h8000_0004, 32'h0, 32'h0,     1'b1});
        vecs.push_back('{1'b1, 32'h0C, 32'h0,        32'h0,     1'b0});
        vecs.push_back('{1'b0, 32'h10, 32'h0,        32'h0,     1'b0});
        vecs.push_back('{1'b1, 32'h0C, 32'h1,        32'h0,     1'b0});
        vecs.push_back('{1'b0, 32'h10, 32'h0,        32'h2,     1'b0});
        vecs.push_back('{1'b1, 32'h00, 32'h555,      32'h0,     1'b1});
        vecs.push_back('{1'b0, 32'h00, 32'h0,        32'h0,     1'b0});
        vecs.push_back('{1'b1, 32'h0C, 32'h1,        32'h0,     1'b1});
        vecs.push_back('{1'b1, 32'h08, 32'h4,        32'h0,     1'b1});
        vecs.push_back('{1'b0, 32'h08, 32'h0,        32'h100,   1'b0});
        vecs.push_back('{1'b1, 32'h10, 32'h1,        32'h0,     1'b0});
        vecs.push_back('{1'b0, 32'h10, 32'h0,        32'h2,     1'b0});
        for (int i = 0; i < vecs.size(); i++) begin
            apb0(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
                 vecs[i].exp_err, 1'b0, $sformatf("vec%0d", i));
        end
        chk("start count after program", 32'(start_cnt0), 32'd1);
        chk("src_addr", src0, 32'h0);
        chk("dst_addr", dst0, 32'h20000);
        chk("len",      len0, 32'h100);
        chk("irq busy", 32'(irq0), 32'h0);

        // ---- Completion and W1C ----
        repeat (50) @(posedge clk);
        #1 done_in0 = 1'b1;
        @(posedge clk); #1;
        done_in0 = 1'b0;
        chk("irq after done", 32'(irq0), 32'h1);
        apb0(1'b0, 32'h10, 32'h0, 32'h1, 1'b0, 1'b0, "status done");
        apb0(1'b1, 32'h10, 32'h1, 32'h0, 1'b0, 1'b0, "status w1c");
        apb0(1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, "status cleared");
        chk("irq cleared", 32'(irq0), 32'h0);
        // done_in while IDLE is ignored
        done_in0 = 1'b1;
        @(posedge clk); #1;
        done_in0 = 1'b0;
        apb0(1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, "status idle done_in");
        chk("irq idle done_in", 32'(irq0), 32'h0);

        // ---- LEN==0 start is rejected ----
        apb0(1'b1, 32'h08, 32'h0, 32'h0, 1'b0, 1'b0, "len zero");
        apb0(1'b1, 32'h0C, 32'h1, 32'h0, 1'b1, 1'b0, "cmd len0");
        apb0(1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, "status len0");
        chk("start count len0", 32'(start_cnt0), 32'd1);

        // ---- Restart, start timing, done during STATUS read ----
        apb0(1'b1, 32'h08, 32'h40, 32'h0, 1'b0, 1'b0, "len 0x40");
        apb0(1'b1, 32'h0C, 32'h1, 32'h0, 1'b0, 1'b0, "cmd restart");
        chk("start cycle after commit", 32'(start0), 32'h1);
        @(posedge clk); #1;
        chk("start one cycle", 32'(start0), 32'h0);
        apb0(1'b0, 32'h10, 32'h0, 32'h2, 1'b0, 1'b1, "status on done_in");
        apb0(1'b0, 32'h10, 32'h0, 32'h1, 1'b0, 1'b0, "status after done_in");
        chk("irq restart done", 32'(irq0), 32'h1);
        apb0(1'b1, 32'h0C, 32'h1, 32'h0, 1'b0, 1'b0, "cmd from done");
        chk("start from done", 32'(start0), 32'h1);
        apb0(1'b0, 32'h10, 32'h0, 32'h2, 1'b0, 1'b0, "status busy again");
        chk("irq busy again", 32'(irq0), 32'h0);
        // CMD write and done_in in the same cycle while BUSY
        apb0(1'b1, 32'h0C, 32'h1, 32'h0, 1'b1, 1'b1, "cmd with done_in");
        apb0(1'b0, 32'h10, 32'h0, 32'h1, 1'b0, 1'b0, "status done honoured");
        chk("start count restarts", 32'(start_cnt0), 32'd3);
        apb0(1'b1, 32'h0C, 32'h1, 32'h0, 1'b0, 1'b0, "cmd before reset");
        apb0(1'b0, 32'h10, 32'h0, 32'h2, 1'b0, 1'b0, "status before reset");

        // ---- Reset during an access while BUSY ----
        bus0.psel = 1'b1; bus0.penable = 1'b0; bus0.pwrite = 1'b1;
        bus0.paddr = 32'h10; bus0.pwdata = 32'h1;
        @(posedge clk); #1;
        bus0.penable = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst pready in reset", 32'(bus0.pready), 32'h0);
        @(posedge clk); #1;
        chk("midrst pready", 32'(bus0.pready), 32'h0);
        chk("midrst len",    len0, 32'h0);
        chk("midrst dst",    dst0, 32'h0);
        chk("midrst irq",    32'(irq0), 32'h0);
        chk("midrst start",  32'(start0), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst aborted access", 32'(bus0.pready), 32'h0);
        @(posedge clk); #1;
        bus0.psel = 1'b0; bus0.penable = 1'b0;
        done_in0 = 1'b1;
        @(posedge clk); #1;
        done_in0 = 1'b0;
        apb0(1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, "status after midrst");
        apb0(1'b0, 32'h08, 32'h0, 32'h0, 1'b0, 1'b0, "len after midrst");
        chk("irq after midrst", 32'(irq0), 32'h0);
        chk("scoreboard drained", 32'(sb_q.size()), 32'h0);

        // ---- Wait states on dut1: 4-cycle access, commit on the last ----
        bus1.psel = 1'b1; bus1.penable = 1'b0; bus1.pwrite = 1'b1;
        bus1.paddr = 32'h0; bus1.pwdata = 32'hABCD_0000;
        @(posedge clk); #1;
        bus1.penable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("ws access%0d pready", k), 32'(bus1.pready), (k == 3) ? 32'h1 : 32'h0);
            chk($sformatf("ws access%0d src", k), src1, 32'h0);
            @(posedge clk); #1;
        end
        chk("ws src committed", src1, 32'hABCD_0000);
        bus1.psel = 1'b1; bus1.penable = 1'b0; bus1.pwrite = 1'b0;
        @(posedge clk); #1;
        bus1.penable = 1'b1;
        begin
            int n;
            for (n = 1; n <= 16; n++) begin
                @(negedge clk);
                if (bus1.pready) break;
                @(posedge clk); #1;
            end
            chk("ws read cycles", 32'(n), 32'd4);
            chk("ws read prdata", bus1.prdata, 32'hABCD_0000);
        end
        @(posedge clk); #1;
        bus1.psel = 1'b0; bus1.penable = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
